// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner
// encoding and a saturating increment used by the statistics counters.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } arb_owner_e;

   localparam int unsigned STAT_W = 32;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Anti-starvation counter for the instruction-fetch port.
// Counts IF arbitrations lost to LS, saturating at MAX_WAIT; force_if_o
// requests that the next contested arbitration go to IF.
module mem_arb_starve_ctr #(
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic clr_i,
   output logic force_if_o
);

   localparam logic [7:0] MAX_V = 8'(MAX_WAIT);

   logic [7:0] cnt_q, cnt_d;

   // Next count: clear wins over increment; increment saturates at MAX_WAIT.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX_V)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_if_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch (IF) and load/store
// (LS). One transaction in flight at a time: IDLE selects and latches a
// request, REQ holds mem_req until mem_gnt, RESP waits for mem_rvalid and
// routes it to the owner. LS has priority unless IF has lost MAX_WAIT
// contested arbitrations in a row.
// Optional build macro MEM_ARB_STATS_EN adds per-owner completion counters
// and a sticky flag for mem_rvalid arriving outside RESP.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 64,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic                clk,
   input  logic                rst,
   // instruction fetch port
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   // load/store port
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_be,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   // memory port
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]         stat_if_cnt,
   output logic [31:0]         stat_ls_cnt,
   output logic                stat_err
`endif
);

   arb_state_e          state_q, state_d;
   arb_owner_e          owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] be_q, be_d;

   logic force_if;
   logic sel_if;
   logic starve_inc;
   logic starve_clr;

   mem_arb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (starve_inc),
      .clr_i      (starve_clr),
      .force_if_o (force_if)
   );

   // IF wins when it is the only requester or when it has waited long enough.
   assign sel_if = if_req && (!ls_req || force_if);

   // Next-state, request latching and combinational handshake outputs.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      starve_inc = 1'b0;
      starve_clr = 1'b0;
      if_gnt     = 1'b0;
      ls_gnt     = 1'b0;
      if_rvalid  = 1'b0;
      ls_rvalid  = 1'b0;
      if_rdata   = '0;
      ls_rdata   = '0;
      case (state_q)
         ST_IDLE: begin
            if (if_req || ls_req) begin
               state_d = ST_REQ;
               if (sel_if) begin
                  owner_d    = OWN_IF;
                  we_d       = 1'b0;
                  addr_d     = if_addr;
                  wdata_d    = '0;
                  be_d       = '0;
                  starve_clr = 1'b1;
               end else begin
                  owner_d    = OWN_LS;
                  we_d       = ls_we;
                  addr_d     = ls_addr;
                  wdata_d    = ls_wdata;
                  be_d       = ls_be;
                  starve_inc = if_req;
               end
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               state_d = ST_RESP;
               if (owner_q == OWN_IF) begin
                  if_gnt = 1'b1;
               end else begin
                  ls_gnt = 1'b1;
               end
            end
         end
         ST_RESP: begin
            // Stores complete here too: mem_rvalid doubles as the write ack.
            if (mem_rvalid) begin
               state_d = ST_IDLE;
               if (owner_q == OWN_IF) begin
                  if_rvalid = 1'b1;
                  if_rdata  = mem_rdata;
               end else begin
                  ls_rvalid = 1'b1;
                  ls_rdata  = mem_rdata;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched transaction registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end

   assign mem_req   = (state_q == ST_REQ);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;

`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_if_cnt_q;
   logic [31:0] stat_ls_cnt_q;
   logic        stat_err_q;
   logic        rsp_done;
   logic        rsp_spurious;

   assign rsp_done     = (state_q == ST_RESP) && mem_rvalid;
   assign rsp_spurious = (state_q != ST_RESP) && mem_rvalid;

   // Completion counters per owner and sticky spurious-response flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_if_cnt_q <= '0;
         stat_ls_cnt_q <= '0;
         stat_err_q    <= 1'b0;
      end else begin
         if (rsp_done && (owner_q == OWN_IF)) begin
            stat_if_cnt_q <= sat_inc(stat_if_cnt_q);
         end
         if (rsp_done && (owner_q == OWN_LS)) begin
            stat_ls_cnt_q <= sat_inc(stat_ls_cnt_q);
         end
         if (rsp_spurious) begin
            stat_err_q <= 1'b1;
         end
      end
   end

   assign stat_if_cnt = stat_if_cnt_q;
   assign stat_ls_cnt = stat_ls_cnt_q;
   assign stat_err    = stat_err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester drivers, a memory model and a
// scoreboard monitor that checks memory-side order and requester responses.
// Build with MEM_ARB_STATS_EN defined to also check the statistics outputs.
module tb_mem_port_arbiter;

   typedef struct {
      logic        own;     // 0 = IF, 1 = LS
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  be;
   } mem_exp_t;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  be;
   } ls_cmd_t;

   typedef struct {
      logic        is_store;
      logic [63:0] rdata;
   } ls_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [63:0] if_rdata;
   logic        ls_req, ls_we;
   logic [63:0] ls_addr, ls_wdata;
   logic [7:0]  ls_be;
   logic        ls_gnt, ls_rvalid;
   logic [63:0] ls_rdata;
   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [63:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_if_cnt, stat_ls_cnt;
   logic        stat_err;
`endif

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_WAIT(8)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
      , .stat_if_cnt(stat_if_cnt), .stat_ls_cnt(stat_ls_cnt), .stat_err(stat_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   logic [63:0] if_cmd_q[$];
   ls_cmd_t     ls_cmd_q[$];
   logic [63:0] if_exp_q[$];
   ls_exp_t     ls_exp_q[$];
   mem_exp_t    exp_mem_q[$];

   // memory model controls
   int  gnt_delay = 0;
   bit  hold_resp = 1'b0;
   bit  inject_rv = 1'b0;
   logic [63:0] mem_img [logic [63:0]];

   // monitor observations
   int if_req_cyc = 0, if_gnt_cyc = 0, if_rvalid_cyc = 0;
   int req_cyc_cnt = 0, last_req_cycles = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [63:0] img_rd(input logic [63:0] a);
      return mem_img.exists(a) ? mem_img[a] : 64'h0;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory model: grants after gnt_delay waiting cycles, answers the next cycle.
   initial begin
      bit          rv_pending;
      logic [63:0] rv_data;
      logic [63:0] old;
      int          wait_cnt;
      rv_pending = 1'b0; rv_data = '0; wait_cnt = 0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
         if (rv_pending) begin
            mem_rvalid = 1'b1; mem_rdata = rv_data; rv_pending = 1'b0;
         end else if (inject_rv) begin
            mem_rvalid = 1'b1; mem_rdata = 64'hBAD; inject_rv = 1'b0;
         end
         if (mem_req && rst) begin
            if (wait_cnt >= gnt_delay) begin
               mem_gnt = 1'b1;
               wait_cnt = 0;
               if (!hold_resp) begin
                  rv_pending = 1'b1;
                  if (mem_we) begin
                     old = img_rd(mem_addr);
                     for (int b = 0; b < 8; b++)
                        if (mem_be[b]) old[8*b +: 8] = mem_wdata[8*b +: 8];
                     mem_img[mem_addr] = old;
                     rv_data = 64'h5A5A;
                  end else begin
                     rv_data = img_rd(mem_addr);
                  end
               end
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // IF requester: holds req/addr until if_gnt is seen.
   initial begin
      bit granted;
      int wait_cyc;
      granted = 1'b0; wait_cyc = 0;
      if_req = 1'b0; if_addr = '0;
      forever begin
         @(posedge clk); #1;
         if (if_req && granted) begin
            if_req = 1'b0; granted = 1'b0;
         end
         if (!if_req && if_cmd_q.size() > 0) begin
            if_addr = if_cmd_q.pop_front();
            if_req = 1'b1; wait_cyc = 0; if_req_cyc = cyc;
         end
         @(negedge clk);
         if (if_req) begin
            if (if_gnt) granted = 1'b1;
            else if (++wait_cyc > 300) begin
               chk("if_gnt_timeout", 64'd1, 64'd0);
               if_req = 1'b0;
            end
         end
      end
   end

   // LS requester: holds req and all fields until ls_gnt is seen.
   initial begin
      bit      granted;
      int      wait_cyc;
      ls_cmd_t c;
      granted = 1'b0; wait_cyc = 0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
      forever begin
         @(posedge clk); #1;
         if (ls_req && granted) begin
            ls_req = 1'b0; granted = 1'b0;
         end
         if (!ls_req && ls_cmd_q.size() > 0) begin
            c = ls_cmd_q.pop_front();
            ls_we = c.we; ls_addr = c.addr; ls_wdata = c.wdata; ls_be = c.be;
            ls_req = 1'b1; wait_cyc = 0;
         end
         @(negedge clk);
         if (ls_req) begin
            if (ls_gnt) granted = 1'b1;
            else if (++wait_cyc > 300) begin
               chk("ls_gnt_timeout", 64'd1, 64'd0);
               ls_req = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: memory-side order/fields and requester responses.
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (mem_req) begin
            req_cyc_cnt++;
            if (exp_mem_q.size() == 0) begin
               chk("mem_req_unexpected", {63'd0, mem_req}, 64'd0);
            end else begin
               chk("mem_addr", mem_addr, exp_mem_q[0].addr);
               chk("mem_we", {63'd0, mem_we}, {63'd0, exp_mem_q[0].we});
               if (mem_gnt) begin
                  chk("mem_wdata", mem_wdata, exp_mem_q[0].wdata);
                  chk("mem_be", {56'd0, mem_be}, {56'd0, exp_mem_q[0].be});
                  chk("gnt_owner", {62'd0, ls_gnt, if_gnt},
                      exp_mem_q[0].own ? 64'd2 : 64'd1);
                  $display("[%0d] grant %s we=%0d addr=0x%0h", cyc,
                           exp_mem_q[0].own ? "LS" : "IF", mem_we, mem_addr);
                  if (if_gnt) if_gnt_cyc = cyc;
                  void'(exp_mem_q.pop_front());
                  last_req_cycles = req_cyc_cnt;
                  req_cyc_cnt = 0;
               end
            end
         end else if (if_gnt || ls_gnt) begin
            chk("gnt_without_mem_req", {62'd0, ls_gnt, if_gnt}, 64'd0);
         end
         if (if_rvalid) begin
            if_rvalid_cyc = cyc;
            if (if_exp_q.size() == 0) chk("if_rvalid_unexpected", 64'd1, 64'd0);
            else begin
               $display("[%0d] IF response rdata=0x%0h", cyc, if_rdata);
               chk("if_rdata", if_rdata, if_exp_q.pop_front());
            end
         end else begin
            chk("if_rdata_idle_zero", if_rdata, 64'd0);
         end
         if (ls_rvalid) begin
            if (ls_exp_q.size() == 0) chk("ls_rvalid_unexpected", 64'd1, 64'd0);
            else begin
               ls_exp_t e;
               e = ls_exp_q.pop_front();
               $display("[%0d] LS response %s rdata=0x%0h", cyc,
                        e.is_store ? "store-ack" : "load", ls_rdata);
               if (!e.is_store) chk("ls_rdata", ls_rdata, e.rdata);
            end
         end else begin
            chk("ls_rdata_idle_zero", ls_rdata, 64'd0);
         end
      end
   end

   task automatic push_if(input logic [63:0] a, input logic [63:0] exp_data, input bit expect_rsp);
      if_cmd_q.push_back(a);
      if (expect_rsp) if_exp_q.push_back(exp_data);
   endtask

   task automatic push_ls(input logic we, input logic [63:0] a, input logic [63:0] wd,
                          input logic [7:0] be, input logic [63:0] exp_data);
      ls_cmd_t c;
      ls_exp_t e;
      c.we = we; c.addr = a; c.wdata = wd; c.be = be;
      ls_cmd_q.push_back(c);
      e.is_store = we; e.rdata = exp_data;
      ls_exp_q.push_back(e);
   endtask

   task automatic exp_mem(input logic own, input logic we, input logic [63:0] a,
                          input logic [63:0] wd, input logic [7:0] be);
      mem_exp_t m;
      m.own = own; m.we = we; m.addr = a; m.wdata = wd; m.be = be;
      exp_mem_q.push_back(m);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((if_cmd_q.size() != 0 || ls_cmd_q.size() != 0 || if_exp_q.size() != 0 ||
              ls_exp_q.size() != 0 || exp_mem_q.size() != 0 || if_req || ls_req) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_drain_timeout"}, {63'd0, n >= 3000}, 64'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      mem_img[64'h1000] = 64'hDEAD;
      mem_img[64'h1008] = 64'h0000_0013_0000_0013;
      mem_img[64'h1100] = 64'hF00D_0001;
      mem_img[64'h1108] = 64'hF00D_0002;
      for (int i = 0; i < 17; i++) mem_img[64'h3000 + 64'(8*i)] = 64'hC0DE_0000 + 64'(i);

      rst = 1'b0;
      repeat (3) @(negedge clk);
      // reset state
      chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
      chk("rst_gnts", {62'd0, if_gnt, ls_gnt}, 64'd0);
      chk("rst_rvalids", {62'd0, if_rvalid, ls_rvalid}, 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      chk("rst_mem_we_be", {55'd0, mem_we, mem_be}, 64'd0);
      chk("rst_rdata", if_rdata | ls_rdata, 64'd0);
      rst = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // 1: IF-only read, immediate grant; latency gnt N+1, rvalid N+2
      exp_mem(1'b0, 1'b0, 64'h1000, 64'd0, 8'h00);
      push_if(64'h1000, 64'hDEAD, 1'b1);
      drain("t1");
      chk("t1_gnt_latency", 64'(if_gnt_cyc - if_req_cyc), 64'd1);
      chk("t1_rvalid_latency", 64'(if_rvalid_cyc - if_req_cyc), 64'd2);

      // 2: simultaneous IF and LS store -> LS first, then IF
      exp_mem(1'b1, 1'b1, 64'h2000, 64'h1122_3344_5566_7788, 8'hFF);
      exp_mem(1'b0, 1'b0, 64'h1008, 64'd0, 8'h00);
      push_ls(1'b1, 64'h2000, 64'h1122_3344_5566_7788, 8'hFF, 64'd0);
      push_if(64'h1008, 64'h0000_0013_0000_0013, 1'b1);
      drain("t2");
      // partial store then read-back
      exp_mem(1'b1, 1'b0, 64'h2000, 64'h1122_3344_5566_7788, 8'hFF);
      exp_mem(1'b1, 1'b1, 64'h2000, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
      exp_mem(1'b1, 1'b0, 64'h2000, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
      push_ls(1'b0, 64'h2000, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788);
      push_ls(1'b1, 64'h2000, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 64'd0);
      push_ls(1'b0, 64'h2000, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 64'h1122_3344_BBBB_BBBB);
      drain("t2b");

      // 3: LS held continuously against IF -> IF wins 9th contested arbitration,
      //    counter cleared, so the second IF again waits 8 LS wins
      for (int i = 0; i < 8; i++) exp_mem(1'b1, 1'b0, 64'h3000 + 64'(8*i), 64'd0, 8'h00);
      exp_mem(1'b0, 1'b0, 64'h1100, 64'd0, 8'h00);
      for (int i = 8; i < 16; i++) exp_mem(1'b1, 1'b0, 64'h3000 + 64'(8*i), 64'd0, 8'h00);
      exp_mem(1'b0, 1'b0, 64'h1108, 64'd0, 8'h00);
      exp_mem(1'b1, 1'b0, 64'h3080, 64'd0, 8'h00);
      for (int i = 0; i < 17; i++)
         push_ls(1'b0, 64'h3000 + 64'(8*i), 64'd0, 8'h00, 64'hC0DE_0000 + 64'(i));
      push_if(64'h1100, 64'hF00D_0001, 1'b1);
      push_if(64'h1108, 64'hF00D_0002, 1'b1);
      drain("t3");

      // 4: grant delayed 3 cycles -> mem_req held 4 cycles, fields stable
      gnt_delay = 3;
      exp_mem(1'b1, 1'b0, 64'h3008, 64'd0, 8'h00);
      push_ls(1'b0, 64'h3008, 64'd0, 8'h00, 64'hC0DE_0001);
      drain("t4");
      chk("t4_req_cycles", 64'(last_req_cycles), 64'd4);
      gnt_delay = 0;

      // 5: reset while waiting in RESP, then a late (spurious) mem_rvalid
      hold_resp = 1'b1;
      exp_mem(1'b0, 1'b0, 64'h1000, 64'd0, 8'h00);
      push_if(64'h1000, 64'd0, 1'b0);
      drain("t5");
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      hold_resp = 1'b0;
      chk("t5_rst_mem_req", {63'd0, mem_req}, 64'd0);
      chk("t5_rst_mem_addr", mem_addr, 64'd0);
      inject_rv = 1'b1;
      repeat (3) @(negedge clk);

      // 5/6: served normally afterwards; 5 IF + 3 LS completions
      exp_mem(1'b1, 1'b0, 64'h2000, 64'd0, 8'h00);
      exp_mem(1'b1, 1'b1, 64'h2008, 64'hEE00_0000_0000_0000, 8'h80);
      exp_mem(1'b1, 1'b0, 64'h2008, 64'hEE00_0000_0000_0000, 8'h80);
      exp_mem(1'b0, 1'b0, 64'h1000, 64'd0, 8'h00);
      exp_mem(1'b0, 1'b0, 64'h1008, 64'd0, 8'h00);
      exp_mem(1'b0, 1'b0, 64'h1100, 64'd0, 8'h00);
      exp_mem(1'b0, 1'b0, 64'h1108, 64'd0, 8'h00);
      exp_mem(1'b0, 1'b0, 64'h1000, 64'd0, 8'h00);
      push_ls(1'b0, 64'h2000, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB);
      push_ls(1'b1, 64'h2008, 64'hEE00_0000_0000_0000, 8'h80, 64'd0);
      push_ls(1'b0, 64'h2008, 64'hEE00_0000_0000_0000, 8'h80, 64'hEE00_0000_0000_0000);
      push_if(64'h1000, 64'hDEAD, 1'b1);
      push_if(64'h1008, 64'h0000_0013_0000_0013, 1'b1);
      push_if(64'h1100, 64'hF00D_0001, 1'b1);
      push_if(64'h1108, 64'hF00D_0002, 1'b1);
      push_if(64'h1000, 64'hDEAD, 1'b1);
      drain("t6");
`ifdef MEM_ARB_STATS_EN
      chk("stat_if_cnt", {32'd0, stat_if_cnt}, 64'd5);
      chk("stat_ls_cnt", {32'd0, stat_ls_cnt}, 64'd3);
      chk("stat_err", {63'd0, stat_err}, 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
